// File: rtl/hex_to_1_digit_cc.sv
// hex_to_1_digit_cc: self-running single-digit hex demo for a common-cathode
// 7-segment display. A prescaler makes a slow square wave. A 4-bit counter
// advances on its rising edge, and a combinational decoder drives the pins.
// Optional macro HEX_EXT_IN_EN adds an external digit input (hex_in, dp_in, ext_sel).
// HALF = CLK_FREQ/(2*OUT_HZ) must be an integer >= 1.
module hex_to_1_digit_cc #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int OUT_HZ   = 2
) (
  input  logic       clk,
  input  logic       rst,
`ifdef HEX_EXT_IN_EN
  input  logic [3:0] hex_in,
  input  logic [0:0] dp_in,
  input  logic       ext_sel,
`endif
  output logic [6:0] Segments,
  output logic       dp,
  output logic       SEL7,
  output logic       clk_slow,
  output logic [3:0] count
);

  localparam int HALF  = CLK_FREQ / (2 * OUT_HZ);
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

  logic [DIV_W-1:0] div_reg, div_next;
  logic             slow_reg, slow_next;
  logic [3:0]       count_reg, count_next;
  logic             tick;
  logic [3:0]       disp_val;
  logic             disp_dp;

  // Tick marks the edge where the slow wave goes 0->1.
  // The counter uses it as an enable, so no derived clock is needed.
  always_comb begin
    div_next   = div_reg + 1'b1;
    slow_next  = slow_reg;
    count_next = count_reg;
    tick       = 1'b0;
    if (div_reg == DIV_LAST) begin
      div_next  = '0;
      slow_next = ~slow_reg;
      tick      = ~slow_reg;
    end
    if (tick) begin
      count_next = count_reg + 4'd1;
    end
  end

  // State registers; reset wins over any pending tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg   <= '0;
      slow_reg  <= 1'b0;
      count_reg <= 4'd0;
    end else begin
      div_reg   <= div_next;
      slow_reg  <= slow_next;
      count_reg <= count_next;
    end
  end

`ifdef HEX_EXT_IN_EN
  // Select the displayed value: the external digit, or the running counter.
  always_comb begin
    disp_val = count_reg;
    disp_dp  = count_reg[0];
    if (ext_sel) begin
      disp_val = hex_in;
      disp_dp  = dp_in[0];
    end
  end
`else
  // The display always shows the running counter. The decimal point marks odd digits.
  always_comb begin
    disp_val = count_reg;
    disp_dp  = count_reg[0];
  end
`endif

  // Hex to segment decoder. Bit order is {g,f,e,d,c,b,a}. B and D use lowercase shapes.
  always_comb begin
    Segments = 7'h00;
    case (disp_val)
      4'h0: Segments = 7'h3F;
      4'h1: Segments = 7'h06;
      4'h2: Segments = 7'h5B;
      4'h3: Segments = 7'h4F;
      4'h4: Segments = 7'h66;
      4'h5: Segments = 7'h6D;
      4'h6: Segments = 7'h7D;
      4'h7: Segments = 7'h07;
      4'h8: Segments = 7'h7F;
      4'h9: Segments = 7'h6F;
      4'hA: Segments = 7'h77;
      4'hB: Segments = 7'h7C;
      4'hC: Segments = 7'h39;
      4'hD: Segments = 7'h5E;
      4'hE: Segments = 7'h79;
      4'hF: Segments = 7'h71;
      default: Segments = 7'h00;
    endcase
  end

  assign dp       = disp_dp;
  assign SEL7     = 1'b0;
  assign clk_slow = slow_reg;
  assign count    = count_reg;

endmodule

// File: tb/tb_hex_to_1_digit_cc.sv
// Scoreboard bench for hex_to_1_digit_cc. The driver pushes one expected vector per clock.
// The monitor pops and checks it on the falling edge.
module tb_hex_to_1_digit_cc;

  typedef struct {
    int         k;
    logic [3:0] cnt;
    logic       slow;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] Segments, seg_def;
  logic       dp, SEL7, clk_slow, dp_def, sel_def, slow_def;
  logic [3:0] count, count_def;
  logic [3:0] hex_in = 4'd0;
  logic [0:0] dp_in = 1'b0;
  logic       ext_sel = 1'b0;

  exp_t       sb_q[$];
  logic [6:0] seg_tab [16];
  int         k = 0;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  hex_to_1_digit_cc #(.CLK_FREQ(20), .OUT_HZ(2)) dut (
    .clk(clk), .rst(rst),
`ifdef HEX_EXT_IN_EN
    .hex_in(hex_in), .dp_in(dp_in), .ext_sel(ext_sel),
`endif
    .Segments(Segments), .dp(dp), .SEL7(SEL7), .clk_slow(clk_slow), .count(count)
  );

  // Default 50 MHz / 2 Hz instance: the run ends long before its first toggle.
  hex_to_1_digit_cc u_def (
    .clk(clk), .rst(rst),
`ifdef HEX_EXT_IN_EN
    .hex_in(4'd0), .dp_in(1'b0), .ext_sel(1'b0),
`endif
    .Segments(seg_def), .dp(dp_def), .SEL7(sel_def), .clk_slow(slow_def), .count(count_def)
  );

  // One clock of stimulus, followed by the expected response for that cycle.
  // With HALF=5, clk_slow rises at k=5,15,25... and count = (k+5)/10 mod 16.
  task automatic cycle(input logic r, input logic es, input logic [3:0] hx, input logic dpi);
    exp_t       e;
    logic [3:0] disp;
    rst = r;
    @(posedge clk);
    #1;
    ext_sel = es;
    hex_in  = hx;
    dp_in   = dpi;
    if (r) k = 0;
    else   k = k + 1;
    e.k    = k;
    e.cnt  = 4'((k + 5) / 10);
    e.slow = ((k / 5) % 2) == 1;
    disp   = es ? hx : e.cnt;
    e.seg  = seg_tab[disp];
    e.dp   = es ? dpi : disp[0];
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: check every queued vector away from the active edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      vectors++;
      $display("vec %0d k=%0d count=%h seg=%h dp=%b slow=%b", vectors, e.k, count, Segments, dp, clk_slow);
      chk("count",    7'(count),    7'(e.cnt));
      chk("clk_slow", 7'(clk_slow), 7'(e.slow));
      chk("Segments", Segments,     e.seg);
      chk("dp",       7'(dp),       7'(e.dp));
      chk("SEL7",     7'(SEL7),     7'd0);
      chk("def_count", 7'(count_def), 7'd0);
      chk("def_slow",  7'(slow_def),  7'd0);
      chk("def_seg",   seg_def,       7'h3F);
      chk("def_sel7",  7'(sel_def),   7'd0);
    end
  end

  initial begin
    seg_tab[0]  = 7'h3F; seg_tab[1]  = 7'h06; seg_tab[2]  = 7'h5B; seg_tab[3]  = 7'h4F;
    seg_tab[4]  = 7'h66; seg_tab[5]  = 7'h6D; seg_tab[6]  = 7'h7D; seg_tab[7]  = 7'h07;
    seg_tab[8]  = 7'h7F; seg_tab[9]  = 7'h6F; seg_tab[10] = 7'h77; seg_tab[11] = 7'h7C;
    seg_tab[12] = 7'h39; seg_tab[13] = 7'h5E; seg_tab[14] = 7'h79; seg_tab[15] = 7'h71;

    // Reset for three cycles, then run 17 slow periods, which includes the F->0 wrap.
    repeat (3) cycle(1'b1, 1'b0, 4'd0, 1'b0);
    repeat (170) cycle(1'b0, 1'b0, 4'd0, 1'b0);

    // Bring the counter to count=9, div=3 (k=88). Then pulse reset for one cycle.
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    repeat (88) cycle(1'b0, 1'b0, 4'd0, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    repeat (30) cycle(1'b0, 1'b0, 4'd0, 1'b0);

`ifdef HEX_EXT_IN_EN
    // External sweep with the counter still running underneath.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      cycle(1'b0, 1'b1, v, ~v[0]);
    end
    repeat (12) cycle(1'b0, 1'b0, 4'd0, 1'b0);
`endif

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending vectors, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
